// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues instruction-memory requests, holds the fetched
// word for decode, computes the next PC on consume, and counts retired words.
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | post-reset; no request, moves to FETCH on the next clock
// FETCH | o_imReq held at o_pc until i_imAck, data captured on the ack edge
// VALID | o_instr presented to decode; held while i_stall, consumed otherwise
// FAULT | bad redirect seen on consume; sticky until reset
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_stall,
    input  logic [1:0]       i_PCSrc,
    input  logic [63:0]      i_seuImm,
    input  logic [63:0]      i_regTarget,
    output logic [63:0]      o_imAddr,
    output logic             o_imReq,
    input  logic             i_imAck,
    input  logic [31:0]      i_imData,
    output logic [31:0]      o_instr,
    output logic             o_instrValid,
    output logic [10:0]      o_opCode,
    output logic [3:0]       o_bCond,
    output logic [4:0]       o_rn,
    output logic [4:0]       o_rm,
    output logic [4:0]       o_rd,
    output logic [63:0]      o_pc,
    output logic             o_fault,
    output logic [CNT_W-1:0] o_retired
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [63:0]      pc_q;
    logic [31:0]      instr_q;
    logic [CNT_W-1:0] retired_q;
    logic [63:0]      target;
    logic             bad_redirect;
    logic             consume;

    // State register; reset wins over every other event, including FAULT.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-PC target, redirect validity, next state and status outputs.
    always_comb begin
        target       = pc_q + 64'd4;
        bad_redirect = 1'b0;
        state_d      = state_q;
        o_imReq      = 1'b0;
        o_instrValid = 1'b0;
        o_fault      = 1'b0;

        case (i_PCSrc)
            2'd0:    target = pc_q + 64'd4;
            2'd1:    target = pc_q + (i_seuImm << 2);
            2'd2:    target = i_regTarget;
            default: begin
                target       = pc_q;
                bad_redirect = 1'b1;
            end
        endcase
        if (target[1:0] != 2'b00) begin
            bad_redirect = 1'b1;
        end

        consume = (state_q == ST_VALID) && !i_stall;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                o_imReq = 1'b1;
                if (i_imAck) begin
                    state_d = ST_VALID;
                end
            end
            ST_VALID: begin
                o_instrValid = 1'b1;
                if (consume) begin
                    state_d = bad_redirect ? ST_FAULT : ST_FETCH;
                end
            end
            default: begin
                o_fault = 1'b1;
            end
        endcase
    end

    // Datapath: capture on ack, advance PC and retire count on consume.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_q      <= RESET_PC;
            instr_q   <= 32'h0;
            retired_q <= '0;
        end else begin
            if ((state_q == ST_FETCH) && i_imAck) begin
                instr_q <= i_imData;
            end
            if (consume) begin
                retired_q <= retired_q + CNT_W'(1);
                if (!bad_redirect) begin
                    pc_q <= target;
                end
            end
        end
    end

    assign o_imAddr  = pc_q;
    assign o_pc      = pc_q;
    assign o_instr   = instr_q;
    assign o_opCode  = instr_q[31:21];
    assign o_bCond   = instr_q[3:0];
    assign o_rn      = instr_q[9:5];
    assign o_rm      = instr_q[20:16];
    assign o_rd      = instr_q[4:0];
    assign o_retired = retired_q;

endmodule
